// File: rtl/symbol_framer.sv
// symbol_framer
// Splits the encoded TX byte stream into OFDM-symbol sized chunks for the
// interleaver. Each byte is tagged with its RATE code on m_axis_tuser and the
// last byte of every symbol carries m_axis_tlast. The SIGNAL symbol is always
// tagged RATE_6M; DATA symbols use the rate captured at packet start.
//
// Optional feature macro: SYMBOL_FRAMER_PAD_EN
//   defined   : a packet ending mid-symbol is completed with zero pad bytes.
//   undefined : the short byte closes the symbol and err pulses.
module symbol_framer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [3:0]       cfg_rate,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [3:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGNAL,
        ST_DATA,
        ST_PAD,
        ST_FLUSH
    } state_t;

    localparam logic [3:0]       RATE_6M = 4'hD;
    localparam logic [CNT_W-1:0] SIG_LEN = CNT_W'(6);

    // Symbol length in bytes for a RATE code; zero marks an unsupported code.
    function automatic logic [CNT_W-1:0] rate_len(input logic [3:0] rate);
        case (rate)
            4'hD, 4'hF: rate_len = CNT_W'(6);
            4'h5, 4'h7: rate_len = CNT_W'(12);
            4'h9, 4'hB: rate_len = CNT_W'(24);
            4'h1, 4'h3: rate_len = CNT_W'(36);
            default:    rate_len = '0;
        endcase
    endfunction

    logic [CNT_W-1:0] len_lut [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_len_lut
        assign len_lut[gi] = rate_len(4'(gi));
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       rate_reg, rate_next;
    logic             cfg_ready_reg;
    logic [WIDTH-1:0] m_tdata_reg, m_tdata_next;
    logic [3:0]       m_tuser_reg, m_tuser_next;
    logic             m_tvalid_reg, m_tvalid_next;
    logic             m_tlast_reg, m_tlast_next;
    logic             err_comb;

    logic             out_free;
    logic             in_fire;
    logic             cfg_fire;
    logic             cfg_bad;
    logic             cur_sig;
    logic [CNT_W-1:0] cur_len;
    logic [3:0]       cur_tuser;
    logic             at_end;
    logic [CNT_W-1:0] cnt_inc;

    // Output register can take a new byte when empty or being drained this cycle.
    assign out_free      = ~m_tvalid_reg | m_axis_tready;
    assign s_axis_tready = ((state_reg == ST_SIGNAL) | (state_reg == ST_DATA)) & out_free;
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign cfg_fire      = cfg_valid & cfg_ready_reg;
    assign cfg_bad       = (len_lut[cfg_rate] == '0);

`ifdef SYMBOL_FRAMER_PAD_EN
    logic pad_sig_reg, pad_sig_next;
    // A pad run that started inside SIGNAL still completes the 6-byte SIGNAL symbol.
    assign cur_sig = (state_reg == ST_SIGNAL) | ((state_reg == ST_PAD) & pad_sig_reg);
`else
    assign cur_sig = (state_reg == ST_SIGNAL);
`endif

    assign cur_len   = cur_sig ? SIG_LEN : len_lut[rate_reg];
    assign cur_tuser = cur_sig ? RATE_6M : rate_reg;
    assign at_end    = (cnt_reg == cur_len - CNT_W'(1));
    assign cnt_inc   = cnt_reg + CNT_W'(1);

    // Next-state, byte counter and output-register loading.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rate_next     = rate_reg;
        m_tdata_next  = m_tdata_reg;
        m_tuser_next  = m_tuser_reg;
        m_tlast_next  = m_tlast_reg;
        m_tvalid_next = m_tvalid_reg & ~m_axis_tready;
        err_comb      = 1'b0;
`ifdef SYMBOL_FRAMER_PAD_EN
        pad_sig_next  = pad_sig_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (cfg_fire) begin
                    if (cfg_bad) begin
                        err_comb = 1'b1;
                    end else begin
                        state_next = ST_SIGNAL;
                        rate_next  = cfg_rate;
                        cnt_next   = '0;
                    end
                end
            end
            ST_SIGNAL, ST_DATA: begin
                if (in_fire) begin
                    m_tdata_next  = s_axis_tdata;
                    m_tuser_next  = cur_tuser;
                    m_tvalid_next = 1'b1;
                    m_tlast_next  = at_end;
                    cnt_next      = at_end ? '0 : cnt_inc;
                    if (s_axis_tlast) begin
                        if (at_end) begin
                            state_next = ST_FLUSH;
                        end else begin
`ifdef SYMBOL_FRAMER_PAD_EN
                            state_next   = ST_PAD;
                            pad_sig_next = (state_reg == ST_SIGNAL);
`else
                            // Short final symbol: close it on this byte and flag it.
                            m_tlast_next = 1'b1;
                            err_comb     = 1'b1;
                            cnt_next     = '0;
                            state_next   = ST_FLUSH;
`endif
                        end
                    end else if (at_end && (state_reg == ST_SIGNAL)) begin
                        state_next = ST_DATA;
                    end
                end
            end
`ifdef SYMBOL_FRAMER_PAD_EN
            ST_PAD: begin
                if (out_free) begin
                    m_tdata_next  = '0;
                    m_tuser_next  = cur_tuser;
                    m_tvalid_next = 1'b1;
                    m_tlast_next  = at_end;
                    if (at_end) begin
                        cnt_next     = '0;
                        pad_sig_next = 1'b0;
                        state_next   = ST_FLUSH;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
`endif
            ST_FLUSH: begin
                if (!m_tvalid_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter, captured rate and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rate_reg      <= '0;
            cfg_ready_reg <= 1'b0;
            m_tdata_reg   <= '0;
            m_tuser_reg   <= '0;
            m_tvalid_reg  <= 1'b0;
            m_tlast_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rate_reg      <= rate_next;
            cfg_ready_reg <= (state_next == ST_IDLE);
            m_tdata_reg   <= m_tdata_next;
            m_tuser_reg   <= m_tuser_next;
            m_tvalid_reg  <= m_tvalid_next;
            m_tlast_reg   <= m_tlast_next;
        end
    end

`ifdef SYMBOL_FRAMER_PAD_EN
    // Remembers whether the current pad run belongs to the SIGNAL symbol.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pad_sig_reg <= 1'b0;
        end else begin
            pad_sig_reg <= pad_sig_next;
        end
    end
`endif

    assign cfg_ready     = cfg_ready_reg;
    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tuser  = m_tuser_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign err           = err_comb;

endmodule

// File: tb/tb_symbol_framer.sv
// tb_symbol_framer
// Directed packets for symbol_framer with a scoreboard queue: the stimulus
// side pushes expected output beats, a negedge monitor pops and compares.
// Honours SYMBOL_FRAMER_PAD_EN the same way as the design.
`timescale 1ns/1ps
module tb_symbol_framer;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [3:0] cfg_rate = 4'h0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] m_axis_tdata;
    logic [3:0] m_axis_tuser;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic       busy;
    logic       err;

    symbol_framer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_rate      (cfg_rate),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err           (err)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct packed {
        logic       last;
        logic [3:0] user;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    tlast_pos[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    beat_cnt = 0;
    int    err_cnt = 0;
    int    cyc = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    bit    mon_en = 1'b1;
    bit    toggle_en = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t held;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic timeout_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, actual no handshake required handshake at %0t", what, $time);
        finish_now();
    endtask

    function automatic int sym_len(input logic [3:0] r);
        case (r)
            4'hD, 4'hF: return 6;
            4'h5, 4'h7: return 12;
            4'h9, 4'hB: return 24;
            4'h1, 4'h3: return 36;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int i, input logic [3:0] r);
        return 8'(i * 37 + int'(r) + 1);
    endfunction

    // m_axis_tready: steady high, or toggling every cycle when toggle_en is set.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (toggle_en) m_axis_tready = ~m_axis_tready;
            else           m_axis_tready = 1'b1;
        end
    end

    // Monitor: transfers complete at the next rising edge; checked at the falling edge.
    always @(negedge aclk) begin
        cyc++;
        if (!aresetn || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (err) err_cnt++;
            if (prev_stall) begin
                chk("stall_hold", int'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                    int'({1'b1, held}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", beat_cnt, 0);
                end else begin
                    chk("beat", int'({m_axis_tlast, m_axis_tuser, m_axis_tdata}), int'(exp_q.pop_front()));
                end
                if (m_axis_tlast) tlast_pos.push_back(beat_cnt);
                if (beat_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            held = '{last: m_axis_tlast, user: m_axis_tuser, data: m_axis_tdata};
        end
    end

    task automatic chk_tlast(input int t0, input int t1, input int t2);
        int req[3];
        int nreq;
        req[0] = t0; req[1] = t1; req[2] = t2;
        nreq = (t0 != 0) + (t1 != 0) + (t2 != 0);
        chk("tlast_count", tlast_pos.size(), nreq);
        for (int k = 0; k < nreq; k++) begin
            chk("tlast_pos", (k < tlast_pos.size()) ? tlast_pos[k] : -1, req[k]);
        end
    endtask

    // One packet: config handshake, scoreboard push, byte stream, drain and per-packet checks.
    task automatic send_packet(input logic [3:0] rate, input int n, input bit skip_cfg,
                               input bit hold_cfg, input int exp_beats,
                               input int t0, input int t1, input int t2, input int exp_err);
        int    g;
        int    len;
        int    total;
        int    err0;
        beat_t b;
        beat_cnt = 0;
        tlast_pos.delete();
        err0 = err_cnt;
        len = sym_len(rate);
`ifdef SYMBOL_FRAMER_PAD_EN
        total = (n <= 6) ? 6 : 6 + ((n - 6 + len - 1) / len) * len;
`else
        total = n;
`endif
        for (int i = 1; i <= total; i++) begin
            b.data = (i <= n) ? pat(i, rate) : 8'h00;
            b.user = (i <= 6) ? 4'hD : rate;
            b.last = (i <= 6) ? (i == 6) : (((i - 6) % len) == 0);
`ifndef SYMBOL_FRAMER_PAD_EN
            if (i == n) b.last = 1'b1;
`endif
            exp_q.push_back(b);
        end
        if (!skip_cfg) begin
            @(posedge aclk);
            #1;
            cfg_rate = rate;
            cfg_valid = 1'b1;
            g = 0;
            do begin
                @(negedge aclk);
                g++;
            end while (!cfg_ready && g < 100);
            if (!cfg_ready) timeout_fail("cfg_accept");
            chk("cfg_err", int'(err), 0);
            @(posedge aclk);
            #1;
            if (hold_cfg) cfg_rate = 4'h7;
            else          cfg_valid = 1'b0;
        end
        for (int i = 1; i <= n; i++) begin
            s_axis_tdata = pat(i, rate);
            s_axis_tvalid = 1'b1;
            s_axis_tlast = (i == n);
            g = 0;
            do begin
                @(negedge aclk);
                g++;
            end while (!s_axis_tready && g < 200);
            if (!s_axis_tready) timeout_fail("s_accept");
            if (i == 1) chk("cfg_ready_busy", int'(cfg_ready), 0);
            if (i == n) chk("err_on_last", int'(err), exp_err);
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        g = 0;
        while (busy && g < 500) begin
            @(negedge aclk);
            g++;
        end
        if (busy) timeout_fail("drain");
        chk("drain_tvalid", int'(m_axis_tvalid), 0);
        chk("beats", beat_cnt, exp_beats);
        chk("exp_q_empty", exp_q.size(), 0);
        chk_tlast(t0, t1, t2);
        chk("err_count", err_cnt - err0, exp_err);
        $display("packet rate=%h bytes=%0d beats=%0d tlasts=%0d", rate, n, beat_cnt, tlast_pos.size());
        if (hold_cfg) begin
            chk("cfg_ready_idle", int'(cfg_ready), 1);
            @(posedge aclk);
            #1;
            cfg_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        chk("rst_s_tready", int'(s_axis_tready), 0);
        chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_m_tlast", int'(m_axis_tlast), 0);
        chk("rst_m_tdata", int'(m_axis_tdata), 0);
        chk("rst_m_tuser", int'(m_axis_tuser), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_cfg_ready", int'(cfg_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // RATE_36M, 54 bytes, m_tready held high: no bubbles.
        send_packet(4'hB, 54, 1'b0, 1'b0, 54, 6, 30, 54, 0);
        chk("no_bubbles", last_cyc - first_cyc, 53);

        // RATE_54M with m_tready toggling.
        toggle_en = 1'b1;
        send_packet(4'h3, 42, 1'b0, 1'b0, 42, 6, 42, 0, 0);
        toggle_en = 1'b0;

        // Bad rate: err pulse, config dropped.
        beat_cnt = 0;
        @(posedge aclk);
        #1;
        cfg_rate = 4'h0;
        cfg_valid = 1'b1;
        @(negedge aclk);
        chk("bad_rate_err", int'(err), 1);
        chk("bad_rate_cfg_ready", int'(cfg_ready), 1);
        @(posedge aclk);
        #1;
        cfg_valid = 1'b0;
        repeat (4) @(negedge aclk);
        chk("bad_rate_err_clear", int'(err), 0);
        chk("bad_rate_cfg_ready_after", int'(cfg_ready), 1);
        chk("bad_rate_busy", int'(busy), 0);
        chk("bad_rate_no_output", beat_cnt, 0);
        $display("bad rate 0 rejected, beats=%0d", beat_cnt);
        send_packet(4'h5, 18, 1'b0, 1'b0, 18, 6, 18, 0, 0);

        // RATE_24M ending 10 bytes into DATA.
`ifdef SYMBOL_FRAMER_PAD_EN
        send_packet(4'h9, 16, 1'b0, 1'b0, 30, 6, 30, 0, 0);
`else
        send_packet(4'h9, 16, 1'b0, 1'b0, 16, 6, 16, 0, 1);
`endif

        // cfg_valid held during a packet; rate changed mid-packet is picked up only afterwards.
        send_packet(4'hD, 12, 1'b0, 1'b1, 12, 6, 12, 0, 0);
        send_packet(4'h7, 18, 1'b1, 1'b0, 18, 6, 18, 0, 0);

        // Reset asserted mid-packet.
        mon_en = 1'b0;
        @(posedge aclk);
        #1;
        cfg_rate = 4'hF;
        cfg_valid = 1'b1;
        @(posedge aclk);
        #1;
        cfg_valid = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'h5A;
        s_axis_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        chk("pre_rst_m_tvalid", int'(m_axis_tvalid), 1);
        chk("pre_rst_busy", int'(busy), 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", int'(m_axis_tvalid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_s_tready", int'(s_axis_tready), 0);
        chk("mid_rst_cfg_ready", int'(cfg_ready), 0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        @(posedge aclk);
        #1;
        chk("mid_rst_release_cfg_ready", int'(cfg_ready), 1);
        $display("reset mid-packet applied and released");
        mon_en = 1'b1;
        send_packet(4'h5, 18, 1'b0, 1'b0, 18, 6, 18, 0, 0);

        finish_now();
    end

    // Global time limit.
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: actual still running required finished at %0t", $time);
        finish_now();
    end

endmodule
